mac_stop_fetch_mult: RTL and testbench
======================================

// Module: mac_stop_fetch_mult
// PURPOSE
//  Upstream stage of the MAC-stop accumulator. Walks i over M, j over N and k over K (k innermost).
//  For each step it reads A[i][k] and B[k][j] from synchronous matrix RAMs and multiplies them.
//  Emits a registered product with matching counter values and a one-cycle mult_done_reg pulse,
//  in exactly the form the accumulator stage consumes.
// PARAMETERS
//  M                      4   rows of A / rows of C (>=2)
//  K                      4   cols of A / rows of B (>=2)
//  N                      4   cols of B / cols of C (>=2)
//  DATA_WIDTH_INIT_MATRIX 32  element width of A and B; product is 2*DATA_WIDTH_INIT_MATRIX
// PORTS
//  clk                           in   1             clock, all logic rising-edge
//  reset                         in   1             synchronous, active-high
//  start                         in   1             begin a full M*N*K pass (sampled in IDLE only)
//  stall                         in   1             block new read issue this cycle
//  a_row_addr                    out  $clog2(M)     A RAM row address (= i)
//  a_col_addr                    out  $clog2(K)     A RAM col address (= k)
//  b_row_addr                    out  $clog2(K)     B RAM row address (= k)
//  b_col_addr                    out  $clog2(N)     B RAM col address (= j)
//  mem_re                        out  1             read enable to both RAMs
//  data_a                        in   DW            A RAM read data, valid 1 cycle after mem_re
//  data_b                        in   DW            B RAM read data, valid 1 cycle after mem_re
//  product_reg                   out  2*DW          registered data_a*data_b
//  matrix_a_row_addr_counter_reg out  $clog2(M)     i of product_reg
//  matrix_a_col_addr_counter_reg out  $clog2(K)     k of product_reg
//  matrix_b_row_addr_counter_reg out  $clog2(K)     k of product_reg
//  matrix_b_col_addr_counter_reg out  $clog2(N)     j of product_reg
//  mult_done_reg                 out  1             product_reg and counters valid this cycle
//  busy                          out  1             high in RUN and DRAIN
//  fetch_done                    out  1             one-cycle pulse at end of pass
// BEHAVIOUR
//  - Reset: all outputs and internal registers are 0; FSM goes to IDLE. Reset wins over every other input.
//  - Reset mid-pass discards in-flight reads; no mult_done_reg is emitted after reset.
//  - FSM states and transitions:
//    IDLE:  start=1 -> RUN; counters cleared.
//    RUN:   each cycle with stall=0: mem_re=1 with addresses (i,k,k,j), then advance.
//           Advance order: k++; at K-1, k=0 and j++; at N-1, j=0 and i++.
//           Issue of (M-1,N-1,K-1) -> DRAIN.
//           stall=1: mem_re=0 and counters hold.
//    DRAIN: wait until both pipeline valid bits are 0; assert fetch_done for 1 cycle; -> IDLE.
//  - Pipeline, per issue in cycle t:
//    stage1 in t+1 captures data_a, data_b and the delayed i/j/k.
//    In t+2: product_reg = captured product, counter regs = its i/j/k, mult_done_reg = 1.
//  - Issued reads always complete; stall never drops or duplicates an operation.
//  - mult_done_reg is 0 in every cycle without a new product. product_reg and the counter regs hold their last value.
//  - Throughput: one product per cycle when stall=0. start -> fetch_done = M*N*K+3 cycles unstalled.
//  - start is ignored while busy. start in the same cycle as fetch_done is ignored (FSM is not yet in IDLE).
//  - Arithmetic: unsigned DW x DW -> 2*DW, exact, no truncation.
// CONFIGURATION
//  MAC_FETCH_SIGNED_EN defined:   operands are two's complement; product is a signed 2*DW result.
//  MAC_FETCH_SIGNED_EN undefined: unsigned multiply.
//  No other behaviour changes.
// STRUCTURE
//  Shared package mac_stop_pkg: FSM state typedef (IDLE/RUN/DRAIN) and the default M/K/N/DW constants.
//  One sub-module, mac_stop_mul_pipe: stage1 capture regs, multiplier and output regs, with valid and counter delay.
//  The top level holds the FSM and the i/j/k counters.
// TESTING (M=K=N=2, DW=8 unless noted)
//  1. Assert reset for 2 cycles mid-run -> all outputs 0 next cycle. A fresh start then yields 8 products.
//  2. A=[[1,2],[3,4]], B=[[5,6],[7,8]], start -> 8 consecutive mult_done_reg pulses.
//     Products in order 5,14,6,16,15,28,18,32 with (i,j,k) = 000,001,010,011,100,101,110,111.
//     fetch_done 11 cycles after start.
//  3. All elements 255 -> every product_reg = 0xFE01.
//  4. stall=1 for 3 cycles after the 3rd issue -> 3-cycle gap in mult_done_reg.
//     Same 8 products in order; fetch_done at cycle 14.
//  5. start pulsed while busy -> ignored: exactly 8 products and a single fetch_done.
//  6. With MAC_FETCH_SIGNED_EN: (-1)*(-1) -> 0x0001; (-128)*127 -> 0xC080.

Source files
------------

// File: rtl/mac_stop_pkg.sv
// -----------------------------------------------------------------------------
// mac_stop_pkg
// Shared definitions for the MAC-stop fetch/multiply stage:
//   - default matrix dimensions (M, K, N) and element width (DW)
//   - fetch FSM state encoding (IDLE / RUN / DRAIN)
// No ports (package).
// -----------------------------------------------------------------------------
package mac_stop_pkg;

   localparam int DEF_M  = 4;
   localparam int DEF_K  = 4;
   localparam int DEF_N  = 4;
   localparam int DEF_DW = 32;

   // IDLE is encoded as zero so a cleared state register is the idle state.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/mac_stop_mul_pipe.sv
// -----------------------------------------------------------------------------
// mac_stop_mul_pipe
// Two-stage read/multiply pipeline behind the matrix RAMs.
//   Stage 1 (cycle after issue): tags the read in flight with its i/j/k.
//   Stage 2 (cycle after that):  registers data_a*data_b with the tag and
//                                 raises o_mult_done_reg for one cycle.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_issue             a RAM read was issued this cycle
//   i_i / i_j / i_k     loop indices of that read
//   i_data_a / i_data_b RAM read data (valid the cycle after i_issue)
//   o_product_reg       registered product, 2*DW bits
//   o_i / o_j / o_k     indices belonging to o_product_reg
//   o_mult_done_reg     o_product_reg is new this cycle
//   o_pending           a read or product is still in the pipeline
// Build option: MAC_FETCH_SIGNED_EN selects a two's complement multiply;
// otherwise operands are unsigned.
// -----------------------------------------------------------------------------
module mac_stop_mul_pipe #(
   parameter int IW = 2,
   parameter int JW = 2,
   parameter int KW = 2,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_issue,
   input  logic [IW-1:0]   i_i,
   input  logic [JW-1:0]   i_j,
   input  logic [KW-1:0]   i_k,
   input  logic [DW-1:0]   i_data_a,
   input  logic [DW-1:0]   i_data_b,
   output logic [2*DW-1:0] o_product_reg,
   output logic [IW-1:0]   o_i,
   output logic [JW-1:0]   o_j,
   output logic [KW-1:0]   o_k,
   output logic            o_mult_done_reg,
   output logic            o_pending
);

   logic            r_v1;
   logic [IW-1:0]   r_i1;
   logic [JW-1:0]   r_j1;
   logic [KW-1:0]   r_k1;
   logic [2*DW-1:0] w_product;

`ifdef MAC_FETCH_SIGNED_EN
   // Both operands signed: the 2*DW context sign-extends them before multiplying.
   assign w_product = $signed(i_data_a) * $signed(i_data_b);
`else
   assign w_product = {{DW{1'b0}}, i_data_a} * {{DW{1'b0}}, i_data_b};
`endif

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge value of the others, modelling real flip-flops.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_v1            <= 1'b0;
         r_i1            <= '0;
         r_j1            <= '0;
         r_k1            <= '0;
         o_product_reg   <= '0;
         o_i             <= '0;
         o_j             <= '0;
         o_k             <= '0;
         o_mult_done_reg <= 1'b0;
      end else begin
         r_v1            <= i_issue;
         o_mult_done_reg <= r_v1;
         if (i_issue) begin
            r_i1 <= i_i;
            r_j1 <= i_j;
            r_k1 <= i_k;
         end
         // RAM data is valid exactly while r_v1 is set; product and tag hold otherwise.
         if (r_v1) begin
            o_product_reg <= w_product;
            o_i           <= r_i1;
            o_j           <= r_j1;
            o_k           <= r_k1;
         end
      end
   end

   assign o_pending = r_v1 | o_mult_done_reg;

endmodule

// File: rtl/mac_stop_fetch_mult.sv
// -----------------------------------------------------------------------------
// mac_stop_fetch_mult
// Upstream stage of the MAC-stop accumulator. Walks i<M, j<N, k<K (k
// innermost), reads A[i][k] and B[k][j] from synchronous RAMs and emits the
// registered product with its indices and a one-cycle mult_done_reg pulse.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   start                    begin a full pass (IDLE only)
//   stall                    suppress read issue this cycle
//   a_row_addr/a_col_addr    A RAM address (i, k)
//   b_row_addr/b_col_addr    B RAM address (k, j)
//   mem_re                   read enable to both RAMs
//   data_a / data_b          RAM read data, one cycle after mem_re
//   product_reg              registered product (2*DW)
//   matrix_*_counter_reg     i/k/k/j of product_reg
//   mult_done_reg            product_reg valid this cycle
//   busy                     RUN or DRAIN
//   fetch_done               one-cycle pulse at end of pass
// Build option: MAC_FETCH_SIGNED_EN (signed multiply, see mac_stop_mul_pipe).
// -----------------------------------------------------------------------------
module mac_stop_fetch_mult
   import mac_stop_pkg::*;
#(
   parameter int M                      = DEF_M,
   parameter int K                      = DEF_K,
   parameter int N                      = DEF_N,
   parameter int DATA_WIDTH_INIT_MATRIX = DEF_DW
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic                                  stall,
   output logic [$clog2(M)-1:0]                  a_row_addr,
   output logic [$clog2(K)-1:0]                  a_col_addr,
   output logic [$clog2(K)-1:0]                  b_row_addr,
   output logic [$clog2(N)-1:0]                  b_col_addr,
   output logic                                  mem_re,
   input  logic [DATA_WIDTH_INIT_MATRIX-1:0]     data_a,
   input  logic [DATA_WIDTH_INIT_MATRIX-1:0]     data_b,
   output logic [2*DATA_WIDTH_INIT_MATRIX-1:0]   product_reg,
   output logic [$clog2(M)-1:0]                  matrix_a_row_addr_counter_reg,
   output logic [$clog2(K)-1:0]                  matrix_a_col_addr_counter_reg,
   output logic [$clog2(K)-1:0]                  matrix_b_row_addr_counter_reg,
   output logic [$clog2(N)-1:0]                  matrix_b_col_addr_counter_reg,
   output logic                                  mult_done_reg,
   output logic                                  busy,
   output logic                                  fetch_done
);

   localparam int IW = $clog2(M);
   localparam int JW = $clog2(N);
   localparam int KW = $clog2(K);
   localparam logic [IW-1:0] I_LAST = IW'(M - 1);
   localparam logic [JW-1:0] J_LAST = JW'(N - 1);
   localparam logic [KW-1:0] K_LAST = KW'(K - 1);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [IW-1:0] r_i;
   logic [JW-1:0] r_j;
   logic [KW-1:0] r_k;
   logic          w_issue;
   logic          w_last;
   logic          w_pending;
   logic [KW-1:0] w_out_k;

   assign w_last = (r_i == I_LAST) && (r_j == J_LAST) && (r_k == K_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_i     <= '0;
         r_j     <= '0;
         r_k     <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE && start) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
         end else if (w_issue) begin
            // k innermost, then j, then i; each wraps so the next pass starts at 0.
            if (r_k == K_LAST) begin
               r_k <= '0;
               if (r_j == J_LAST) begin
                  r_j <= '0;
                  r_i <= (r_i == I_LAST) ? '0 : r_i + 1'b1;
               end else begin
                  r_j <= r_j + 1'b1;
               end
            end else begin
               r_k <= r_k + 1'b1;
            end
         end
      end
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement leaves a value unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      fetch_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!stall) begin
               w_issue = 1'b1;
               if (w_last) w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Pass ends only once the last product has left the pipeline.
            if (!w_pending) begin
               fetch_done  = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign mem_re     = w_issue;
   assign busy       = (r_state != ST_IDLE);
   assign a_row_addr = r_i;
   assign a_col_addr = r_k;
   assign b_row_addr = r_k;
   assign b_col_addr = r_j;

   mac_stop_mul_pipe #(
      .IW (IW),
      .JW (JW),
      .KW (KW),
      .DW (DATA_WIDTH_INIT_MATRIX)
   ) u_pipe (
      .clk             (clk),
      .reset           (reset),
      .i_issue         (w_issue),
      .i_i             (r_i),
      .i_j             (r_j),
      .i_k             (r_k),
      .i_data_a        (data_a),
      .i_data_b        (data_b),
      .o_product_reg   (product_reg),
      .o_i             (matrix_a_row_addr_counter_reg),
      .o_j             (matrix_b_col_addr_counter_reg),
      .o_k             (w_out_k),
      .o_mult_done_reg (mult_done_reg),
      .o_pending       (w_pending)
   );

   assign matrix_a_col_addr_counter_reg = w_out_k;
   assign matrix_b_row_addr_counter_reg = w_out_k;

endmodule

// File: tb/tb_mac_stop_fetch_mult.sv
// -----------------------------------------------------------------------------
// tb_mac_stop_fetch_mult
// Bench for mac_stop_fetch_mult with M=K=N=2, DW=8. A behavioural RAM model
// answers reads; expected products come from a table of hand-computed passes
// and from a plain-arithmetic matrix model for random passes.
// Honours MAC_FETCH_SIGNED_EN in its reference multiply.
// -----------------------------------------------------------------------------
module tb_mac_stop_fetch_mult;

   localparam int M   = 2;
   localparam int K   = 2;
   localparam int N   = 2;
   localparam int DW  = 8;
   localparam int OPS = M * N * K;
   localparam int IW  = $clog2(M);
   localparam int JW  = $clog2(N);
   localparam int KW  = $clog2(K);

   logic            clk = 1'b0;
   logic            reset;
   logic            start;
   logic            stall;
   logic [IW-1:0]   a_row_addr;
   logic [KW-1:0]   a_col_addr;
   logic [KW-1:0]   b_row_addr;
   logic [JW-1:0]   b_col_addr;
   logic            mem_re;
   logic [DW-1:0]   data_a;
   logic [DW-1:0]   data_b;
   logic [2*DW-1:0] product_reg;
   logic [IW-1:0]   a_row_cnt;
   logic [KW-1:0]   a_col_cnt;
   logic [KW-1:0]   b_row_cnt;
   logic [JW-1:0]   b_col_cnt;
   logic            mult_done_reg;
   logic            busy;
   logic            fetch_done;

   mac_stop_fetch_mult #(
      .M (M), .K (K), .N (N), .DATA_WIDTH_INIT_MATRIX (DW)
   ) dut (
      .clk                           (clk),
      .reset                         (reset),
      .start                         (start),
      .stall                         (stall),
      .a_row_addr                    (a_row_addr),
      .a_col_addr                    (a_col_addr),
      .b_row_addr                    (b_row_addr),
      .b_col_addr                    (b_col_addr),
      .mem_re                        (mem_re),
      .data_a                        (data_a),
      .data_b                        (data_b),
      .product_reg                   (product_reg),
      .matrix_a_row_addr_counter_reg (a_row_cnt),
      .matrix_a_col_addr_counter_reg (a_col_cnt),
      .matrix_b_row_addr_counter_reg (b_row_cnt),
      .matrix_b_col_addr_counter_reg (b_col_cnt),
      .mult_done_reg                 (mult_done_reg),
      .busy                          (busy),
      .fetch_done                    (fetch_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous RAMs, row-major: A[i][k] at i*K+k, B[k][j] at k*N+j.
   logic [DW-1:0] mem_a [M*K];
   logic [DW-1:0] mem_b [K*N];
   always @(posedge clk) begin
      if (mem_re) begin
         data_a <= mem_a[int'(a_row_addr) * K + int'(a_col_addr)];
         data_b <= mem_b[int'(b_row_addr) * N + int'(b_col_addr)];
      end
   end

   typedef struct {
      logic [DW-1:0]   a [M*K];
      logic [DW-1:0]   b [K*N];
      int              stall_at;     // stall after this many issues (0 = never)
      int              stall_len;
      int              restart_cyc;  // cycle (after start) to pulse start again, 0 = never
      int              exp_lat;      // start -> fetch_done, in cycles
      logic [2*DW-1:0] exp_prod [OPS];
   } vec_t;

   vec_t cur;
   vec_t vecs [6];

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [2*DW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
      int pa, pb;
`ifdef MAC_FETCH_SIGNED_EN
      pa = int'($signed(a));
      pb = int'($signed(b));
`else
      pa = int'(a);
      pb = int'(b);
`endif
      return (2*DW)'(pa * pb);
   endfunction

   task automatic check_all_zero(input string name);
      check(name, {product_reg, a_row_cnt, a_col_cnt, b_row_cnt, b_col_cnt,
                   a_row_addr, a_col_addr, b_row_addr, b_col_addr,
                   mem_re, mult_done_reg, busy, fetch_done}, 64'd0);
   endtask

   // One full pass with the matrices in cur; checks each product, its indices,
   // its arrival cycle (issue + 2), and the fetch_done latency and count.
   task automatic run_pass(input bit rand_stall);
      int issues, prods, fds, fd_cyc, stall_left, stall_cnt, s, exp_lat;
      int ii, jj, kk;
      int issue_cyc [OPS];
      bit armed;
      issues = 0; prods = 0; fds = 0; fd_cyc = -1; stall_left = 0; stall_cnt = 0;
      armed = (cur.stall_at > 0);
      for (int n = 0; n < M*K; n++) mem_a[n] = cur.a[n];
      for (int n = 0; n < K*N; n++) mem_b[n] = cur.b[n];
      @(posedge clk); #1;
      start = 1'b1;
      stall = 1'b0;
      s = cyc;
      for (int c = 1; c <= 200; c++) begin
         @(posedge clk); #1;
         start = (cur.restart_cyc == c);
         if (rand_stall) stall = ($urandom_range(0, 3) == 0);
         else if (stall_left > 0) begin
            stall = 1'b1;
            stall_left--;
         end else stall = 1'b0;
         @(negedge clk);
         if (stall) check("no_issue_while_stalled", mem_re, 0);
         if (stall && issues < OPS) stall_cnt++;
         if (mem_re) begin
            if (issues < OPS) begin
               ii = issues / (N*K); jj = (issues / K) % N; kk = issues % K;
               issue_cyc[issues] = cyc;
               check($sformatf("read_addr[%0d]", issues),
                     {a_row_addr, a_col_addr, b_row_addr, b_col_addr},
                     {IW'(ii), KW'(kk), KW'(kk), JW'(jj)});
            end
            issues++;
            if (armed && issues == cur.stall_at) begin
               stall_left = cur.stall_len;
               armed = 1'b0;
            end
         end
         if (mult_done_reg) begin
            if (prods < OPS) begin
               ii = prods / (N*K); jj = (prods / K) % N; kk = prods % K;
               check($sformatf("product[%0d]", prods), product_reg, cur.exp_prod[prods]);
               check($sformatf("ijk[%0d]", prods),
                     {a_row_cnt, a_col_cnt, b_row_cnt, b_col_cnt},
                     {IW'(ii), KW'(kk), KW'(kk), JW'(jj)});
               check($sformatf("product_cycle[%0d]", prods), cyc, issue_cyc[prods] + 2);
            end
            prods++;
         end
         if (fetch_done) begin
            fds++;
            if (fd_cyc < 0) fd_cyc = cyc - s;
         end
         if (fd_cyc >= 0 && (cyc - s) >= fd_cyc + 5) break;
      end
      exp_lat = rand_stall ? (OPS + 3 + stall_cnt) : cur.exp_lat;
      check("fetch_done_latency", fd_cyc, exp_lat);
      check("issue_count", issues, OPS);
      check("product_count", prods, OPS);
      check("fetch_done_count", fds, 1);
      check("idle_after_pass", busy, 0);
      start = 1'b0;
      stall = 1'b0;
   endtask

   initial begin
      int md_seen;

      // Table of directed passes.
      vecs[0].a = '{8'd1, 8'd2, 8'd3, 8'd4};
      vecs[0].b = '{8'd5, 8'd6, 8'd7, 8'd8};
      vecs[0].stall_at = 0; vecs[0].stall_len = 0; vecs[0].restart_cyc = 0; vecs[0].exp_lat = 11;
      vecs[0].exp_prod = '{16'd5, 16'd14, 16'd6, 16'd16, 16'd15, 16'd28, 16'd18, 16'd32};

      for (int n = 0; n < 4; n++) begin
         vecs[1].a[n] = 8'hFF; vecs[1].b[n] = 8'hFF;
         vecs[5].a[n] = 8'h80; vecs[5].b[n] = 8'h7F;
      end
      vecs[1].stall_at = 0; vecs[1].stall_len = 0; vecs[1].restart_cyc = 0; vecs[1].exp_lat = 11;
      vecs[5].stall_at = 0; vecs[5].stall_len = 0; vecs[5].restart_cyc = 0; vecs[5].exp_lat = 11;
      for (int n = 0; n < OPS; n++) begin
`ifdef MAC_FETCH_SIGNED_EN
         vecs[1].exp_prod[n] = 16'h0001;
         vecs[5].exp_prod[n] = 16'hC080;
`else
         vecs[1].exp_prod[n] = 16'hFE01;
         vecs[5].exp_prod[n] = 16'h3F80;
`endif
      end

      vecs[2] = vecs[0]; vecs[2].stall_at = 3; vecs[2].stall_len = 3; vecs[2].exp_lat = 14;
      vecs[3] = vecs[0]; vecs[3].restart_cyc = 5;
      vecs[4] = vecs[0]; vecs[4].restart_cyc = 11;

      // Power-on reset.
      reset = 1'b1; start = 1'b0; stall = 1'b0;
      for (int n = 0; n < 4; n++) begin
         mem_a[n] = '0; mem_b[n] = '0;
      end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_all_zero("reset_state");

      // Reset mid-pass discards the reads in flight.
      cur = vecs[0];
      for (int n = 0; n < 4; n++) begin
         mem_a[n] = cur.a[n]; mem_b[n] = cur.b[n];
      end
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_all_zero("midrun_reset_state");
      md_seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (mult_done_reg || busy) md_seen++;
      end
      check("quiet_after_reset", md_seen, 0);

      // Directed table.
      for (int v = 0; v < 6; v++) begin
         cur = vecs[v];
         run_pass(1'b0);
      end

      // Random matrices with random stalls against the matrix model.
      for (int r = 0; r < 4; r++) begin
         for (int n = 0; n < 4; n++) begin
            cur.a[n] = DW'($urandom);
            cur.b[n] = DW'($urandom);
         end
         for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
               for (int k = 0; k < K; k++)
                  cur.exp_prod[(i*N + j)*K + k] = ref_mul(cur.a[i*K + k], cur.b[k*N + j]);
         cur.stall_at = 0; cur.stall_len = 0; cur.restart_cyc = 0; cur.exp_lat = 0;
         run_pass(1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
